send_cmd_scheduler: RTL and testbench

//  Generalised packet-send trigger generator for the MAC send_packet_N_control interfaces.

---
 rtl/send_sched_pkg.sv | 17 +
 rtl/send_cmd_scheduler_if.sv | 25 ++
 rtl/send_cmd_channel.sv | 92 +++++++++
 rtl/send_cmd_scheduler.sv | 67 ++++++
 tb/tb_send_cmd_scheduler.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/send_sched_pkg.sv
// Shared types and slot arithmetic for the packet-send trigger scheduler.
package send_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    DONE  = 2'd2
  } ch_state_t;

  // Counter value at which channel ch is offered its send slot.
  function automatic logic [31:0] slot_of(input int unsigned ch,
                                          input logic [31:0] offset0,
                                          input logic [31:0] stagger);
    return offset0 + ch * stagger;
  endfunction

endpackage

// File: rtl/send_cmd_scheduler_if.sv
// Control inputs and per-channel send/address/statistics outputs of the scheduler.
interface send_cmd_scheduler_if #(
  parameter int N_CH   = 2,
  parameter int ADDR_W = 25,
  parameter int STAT_W = 16
);
  logic                     run_en;
  logic                     oneshot;
  logic [N_CH-1:0]          ch_mask;
  logic [N_CH-1:0]          ch_busy;
  logic [N_CH-1:0]          cmd_send;
  logic [N_CH*ADDR_W-1:0]   start_addr;
  logic [N_CH*STAT_W-1:0]   sent_cnt;
  logic [N_CH*STAT_W-1:0]   skip_cnt;

  modport master (
    output run_en, oneshot, ch_mask, ch_busy,
    input  cmd_send, start_addr, sent_cnt, skip_cnt
  );

  modport slave (
    input  run_en, oneshot, ch_mask, ch_busy,
    output cmd_send, start_addr, sent_cnt, skip_cnt
  );
endinterface

// File: rtl/send_cmd_channel.sv
// One send channel: slot FSM, fixed-length pulse, frame-ring address and saturating stats.
module send_cmd_channel
  import send_sched_pkg::*;
#(
  parameter int                PULSE_LEN = 3,
  parameter int                ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 25'd1,
  parameter logic [ADDR_W-1:0] ADDR_STEP = 25'd64,
  parameter int                N_FRAMES  = 4,
  parameter int                STAT_W    = 16
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              hit_i,
  input  logic              mask_i,
  input  logic              busy_i,
  input  logic              run_en_i,
  input  logic              oneshot_i,
  output logic              cmd_send_o,
  output logic [ADDR_W-1:0] start_addr_o,
  output logic [STAT_W-1:0] sent_cnt_o,
  output logic [STAT_W-1:0] skip_cnt_o
);

  localparam int TMR_W = $clog2(PULSE_LEN + 1);
  localparam int IDX_W = $clog2(N_FRAMES + 1);

  ch_state_t         state_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [IDX_W-1:0]  idx_q;
  logic              cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [STAT_W-1:0] sent_q;
  logic [STAT_W-1:0] skip_q;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // tmr_q counts the remaining high clocks after the current one.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      cmd_q   <= 1'b0;
      addr_q  <= ADDR_BASE;
      sent_q  <= '0;
      skip_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit_i && mask_i) begin
            if (busy_i) begin
              skip_q <= sat_inc(skip_q);
            end else begin
              state_q <= PULSE;
              cmd_q   <= 1'b1;
              tmr_q   <= TMR_W'(PULSE_LEN - 1);
              sent_q  <= sat_inc(sent_q);
            end
          end
        end
        PULSE: begin
          if (tmr_q == '0) begin
            cmd_q   <= 1'b0;
            state_q <= oneshot_i ? DONE : IDLE;
            if (idx_q == IDX_W'(N_FRAMES - 1)) begin
              idx_q  <= '0;
              addr_q <= ADDR_BASE;
            end else begin
              idx_q  <= idx_q + 1'b1;
              addr_q <= addr_q + ADDR_STEP;
            end
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        DONE: begin
          if (!run_en_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_send_o   = cmd_q;
  assign start_addr_o = addr_q;
  assign sent_cnt_o   = sent_q;
  assign skip_cnt_o   = skip_q;

endmodule

// File: rtl/send_cmd_scheduler.sv
// Staggered cmd_send generator: shared period counter, per-channel slot compare, output packing.
module send_cmd_scheduler
  import send_sched_pkg::*;
#(
  parameter int                N_CH      = 2,
  parameter int                CNT_W     = 32,
  parameter int                ADDR_W    = 25,
  parameter logic [31:0]       PERIOD    = 32'd528,
  parameter logic [31:0]       OFFSET0   = 32'd255,
  parameter logic [31:0]       STAGGER   = 32'd256,
  parameter int                PULSE_LEN = 3,
  parameter logic [ADDR_W-1:0] ADDR_BASE = 25'd1,
  parameter logic [ADDR_W-1:0] ADDR_STEP = 25'd64,
  parameter int                N_FRAMES  = 4,
  parameter int                STAT_W    = 16
) (
  input  logic                  clk_50,
  input  logic                  rst_n,
  send_cmd_scheduler_if.slave   bus
);

  if (OFFSET0 + (N_CH - 1) * STAGGER + PULSE_LEN >= PERIOD) begin : g_bad_schedule
    $fatal(1, "send_cmd_scheduler: last slot plus pulse does not fit in PERIOD");
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [N_CH-1:0]  hit;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.run_en) begin
      cnt_d = (cnt_q == CNT_W'(PERIOD - 32'd1)) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign hit[g] = bus.run_en && (cnt_q == CNT_W'(slot_of(g, OFFSET0, STAGGER)));

    send_cmd_channel #(
      .PULSE_LEN (PULSE_LEN),
      .ADDR_W    (ADDR_W),
      .ADDR_BASE (ADDR_BASE),
      .ADDR_STEP (ADDR_STEP),
      .N_FRAMES  (N_FRAMES),
      .STAT_W    (STAT_W)
    ) u_ch (
      .clk_50       (clk_50),
      .rst_n        (rst_n),
      .hit_i        (hit[g]),
      .mask_i       (bus.ch_mask[g]),
      .busy_i       (bus.ch_busy[g]),
      .run_en_i     (bus.run_en),
      .oneshot_i    (bus.oneshot),
      .cmd_send_o   (bus.cmd_send[g]),
      .start_addr_o (bus.start_addr[g*ADDR_W +: ADDR_W]),
      .sent_cnt_o   (bus.sent_cnt[g*STAT_W +: STAT_W]),
      .skip_cnt_o   (bus.skip_cnt[g*STAT_W +: STAT_W])
    );
  end

endmodule

// File: tb/tb_send_cmd_scheduler.sv
// Self-checking bench: randomized and directed stimulus against a behavioural schedule model.
module tb_send_cmd_scheduler;

  localparam int NCH   = 2;
  localparam int AW    = 25;
  localparam int SW    = 16;
  localparam int PER   = 528;
  localparam int OFF0  = 255;
  localparam int STAG  = 256;
  localparam int PLEN  = 3;
  localparam int ABASE = 1;
  localparam int ASTEP = 64;
  localparam int NFR   = 4;
  localparam int SMAX  = 65535;

  logic clk = 1'b0;
  logic rst_n;

  send_cmd_scheduler_if #(.N_CH(NCH), .ADDR_W(AW), .STAT_W(SW)) bus ();

  send_cmd_scheduler dut (
    .clk_50 (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #10 clk = ~clk;

  // Behavioural model: slot schedule in plain integers.
  int m_cnt;
  int m_left   [NCH];
  bit m_done   [NCH];
  int m_frames [NCH];
  int m_sent   [NCH];
  int m_skip   [NCH];
  bit m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      for (int c = 0; c < NCH; c++) begin
        m_left[c] = 0; m_done[c] = 0; m_frames[c] = 0; m_sent[c] = 0; m_skip[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        m_hit = bus.run_en && (m_cnt == OFF0 + c * STAG);
        if (m_left[c] > 0) begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            m_frames[c]++;
            if (bus.oneshot) m_done[c] = 1;
          end
        end else if (m_done[c]) begin
          if (!bus.run_en) m_done[c] = 0;
        end else if (m_hit && bus.ch_mask[c]) begin
          if (bus.ch_busy[c]) begin
            if (m_skip[c] < SMAX) m_skip[c]++;
          end else begin
            m_left[c] = PLEN;
            if (m_sent[c] < SMAX) m_sent[c]++;
          end
        end
      end
      if (bus.run_en) m_cnt = (m_cnt + 1) % PER;
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int rise_cnt  [NCH] = '{0, 0};
  int rise_cyc  [NCH] = '{0, 0};
  int rise_addr [NCH] = '{0, 0};
  int hi_len    [NCH] = '{0, 0};
  int last_w    [NCH] = '{0, 0};
  bit prev_cmd  [NCH] = '{0, 0};

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint exp_addr(input int c);
    return longint'((ABASE + (m_frames[c] % NFR) * ASTEP) % (1 << AW));
  endfunction

  task automatic compare_all();
    if (!rst_n) cyc = 0; else cyc++;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("cmd_send[%0d]", c), bus.cmd_send[c], (m_left[c] > 0) ? 1 : 0);
      chk($sformatf("start_addr[%0d]", c), bus.start_addr[c*AW +: AW], exp_addr(c));
      chk($sformatf("sent_cnt[%0d]", c), bus.sent_cnt[c*SW +: SW], m_sent[c]);
      chk($sformatf("skip_cnt[%0d]", c), bus.skip_cnt[c*SW +: SW], m_skip[c]);
      if (bus.cmd_send[c] && !prev_cmd[c]) begin
        rise_cnt[c]++;
        rise_cyc[c]  = cyc;
        rise_addr[c] = int'(bus.start_addr[c*AW +: AW]);
      end
      if (bus.cmd_send[c]) hi_len[c]++;
      else if (prev_cmd[c]) begin
        last_w[c] = hi_len[c];
        hi_len[c] = 0;
      end
      prev_cmd[c] = bus.cmd_send[c];
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    #1;
  endtask

  task automatic wait_rise(input int c, input int bound, output int n);
    int r;
    r = rise_cnt[c];
    n = 0;
    while (rise_cnt[c] == r && n < bound) begin
      step();
      n++;
    end
    if (rise_cnt[c] == r) chk($sformatf("timeout_rise_ch%0d", c), 0, 1);
  endtask

  task automatic do_reset(input bit os);
    rst_n = 1'b0;
    bus.run_en = 1'b0; bus.oneshot = os; bus.ch_mask = 2'b11; bus.ch_busy = 2'b00;
    repeat (3) step();
    rst_n = 1'b1;
    bus.run_en = 1'b1;
  endtask

  int n;
  int r0, r1;
  int lit_addr [5] = '{1, 65, 129, 193, 1};
  int off_left;

  initial begin
    // Scenario: defaults from reset and the address ring over five periods.
    rst_n = 1'b0;
    bus.run_en = 1'b0; bus.oneshot = 1'b0; bus.ch_mask = 2'b11; bus.ch_busy = 2'b00;
    repeat (3) step();
    chk("reset_cmd", bus.cmd_send, 0);
    chk("reset_addr0", bus.start_addr[0 +: AW], 1);
    chk("reset_addr1", bus.start_addr[AW +: AW], 1);
    chk("reset_sent", bus.sent_cnt, 0);
    chk("reset_skip", bus.skip_cnt, 0);
    rst_n = 1'b1;
    bus.run_en = 1'b1;

    for (int k = 0; k < 5; k++) begin
      wait_rise(0, 1200, n);
      chk($sformatf("ch0_rise_cyc_%0d", k), rise_cyc[0], 256 + 528 * k);
      chk($sformatf("ch0_rise_addr_%0d", k), rise_addr[0], lit_addr[k]);
      for (int j = 0; j < 2; j++) begin
        step();
        chk("ch0_high_mid", bus.cmd_send[0], 1);
        chk("ch0_addr_stable", bus.start_addr[0 +: AW], lit_addr[k]);
      end
      step();
      chk("ch0_low_after3", bus.cmd_send[0], 0);
      if (k == 0) begin
        wait_rise(1, 600, n);
        chk("ch1_first_rise_cyc", rise_cyc[1], 512);
        chk("ch1_first_addr", rise_addr[1], 1);
      end
    end

    // Scenario: ch1 busy across its slot.
    n = 0;
    while (m_cnt != 500 && n < 1200) begin step(); n++; end
    bus.ch_busy = 2'b10;
    while (m_cnt != 520 && n < 2400) begin step(); n++; end
    bus.ch_busy = 2'b00;
    step();
    chk("busy_skip1", bus.skip_cnt[SW +: SW], 1);
    chk("busy_skip0", bus.skip_cnt[0 +: SW], 0);
    chk("busy_sent1", bus.sent_cnt[SW +: SW], 4);
    chk("busy_sent0", bus.sent_cnt[0 +: SW], 5);
    chk("busy_addr1", bus.start_addr[AW +: AW], 1);

    // Scenario: run_en drops during a ch0 pulse.
    n = 0;
    while (m_cnt != 256 && n < 1200) begin step(); n++; end
    chk("pause_ch0_high", bus.cmd_send[0], 1);
    bus.run_en = 1'b0;
    repeat (20) step();
    chk("pause_width", last_w[0], 3);
    chk("pause_ch0_low", bus.cmd_send[0], 0);
    bus.run_en = 1'b1;
    wait_rise(1, 600, n);
    chk("resume_ch1_delay", n, 256);
    chk("resume_ch1_addr", rise_addr[1], 1);

    // Randomized traffic.
    off_left = 0;
    for (int i = 0; i < 6000; i++) begin
      if (off_left > 0) begin
        off_left--;
        if (off_left == 0) bus.run_en = 1'b1;
      end else if ($urandom_range(0, 399) == 0) begin
        bus.run_en = 1'b0;
        off_left = $urandom_range(1, 40);
      end
      bus.ch_busy[0] = ($urandom_range(0, 3) == 0);
      bus.ch_busy[1] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) bus.ch_mask = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 999) == 0) bus.oneshot = ~bus.oneshot;
      step();
    end

    // Scenario: asynchronous reset in the middle of a ch0 pulse.
    bus.oneshot = 1'b0; bus.ch_mask = 2'b11; bus.ch_busy = 2'b00; bus.run_en = 1'b0;
    step();
    bus.run_en = 1'b1;
    wait_rise(0, 1200, n);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd", bus.cmd_send, 0);
    chk("arst_sent", bus.sent_cnt, 0);
    chk("arst_skip", bus.skip_cnt, 0);
    chk("arst_addr0", bus.start_addr[0 +: AW], 1);
    chk("arst_addr1", bus.start_addr[AW +: AW], 1);
    repeat (3) step();
    rst_n = 1'b1;
    wait_rise(0, 600, n);
    chk("restart_ch0_cyc", rise_cyc[0], 256);
    chk("restart_ch0_addr", rise_addr[0], 1);

    // Scenario: oneshot fires once per run_en interval.
    do_reset(1'b1);
    r0 = rise_cnt[0]; r1 = rise_cnt[1];
    repeat (1700) step();
    chk("oneshot_ch0_count", rise_cnt[0] - r0, 1);
    chk("oneshot_ch1_count", rise_cnt[1] - r1, 1);
    bus.run_en = 1'b0;
    step();
    bus.run_en = 1'b1;
    repeat (1100) step();
    chk("oneshot_ch0_rearm", rise_cnt[0] - r0, 2);
    chk("oneshot_ch1_rearm", rise_cnt[1] - r1, 2);
    chk("oneshot_sent0", bus.sent_cnt[0 +: SW], 2);
    chk("oneshot_addr0", bus.start_addr[0 +: AW], 129);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "global timeout");
  end

endmodule
